// File: rtl/encoder32to5_stream_if.sv
// encoder32to5_stream_if: vector-in / index-out valid-ready stream bundle for the bitmap encoder
interface encoder32to5_stream_if #(
  parameter int WIDTH = 32
);
  localparam int IDX_W = $clog2(WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_zero;
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_zero
  );
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_zero
  );
endinterface

// File: rtl/encoder32to5_stream.sv
// encoder32to5_stream: streams the index of every set bit of a multi-hot vector, one beat per set bit
// Define ENC_MSB_FIRST_EN to scan from the top bit downward instead of LSB first.
module encoder32to5_stream #(
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  encoder32to5_stream_if.slave  bus,
  output logic                  busy
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t           state, state_nxt;
  logic [WIDTH-1:0] pend, scan;
  logic [IDX_W-1:0] idx_q, enc;
  logic             last_q, zero_q, accept, fire, load, enc_one, vec_zero;
  // scan is either the fresh vector or pend with the current beat's bit removed
  always_comb begin
    accept   = bus.in_valid && state == IDLE;
    fire     = state == EMIT && bus.out_ready;
    load     = accept || fire;
    vec_zero = bus.in_vec == '0;
    scan     = accept ? bus.in_vec : pend & ~(WIDTH'(1) << idx_q);
    enc      = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) if (scan[i]) enc = IDX_W'(i);
`else
    for (int i = WIDTH - 1; i >= 0; i--) if (scan[i]) enc = IDX_W'(i);
`endif
    enc_one   = scan != '0 && (scan & (scan - WIDTH'(1))) == '0;
    state_nxt = accept ? EMIT : (fire && last_q) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pend   <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      pend   <= load ? scan : pend;
      idx_q  <= load ? enc : idx_q;
      last_q <= accept ? (vec_zero || enc_one) : fire ? enc_one : last_q;
      zero_q <= accept ? vec_zero : fire ? 1'b0 : zero_q;
    end
  end
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == EMIT;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
  assign bus.out_zero  = zero_q;
  assign busy          = state == EMIT;
endmodule
